ps2_transmitter: RTL and testbench
==================================

# ps2_transmitter

Host-to-device PS/2 transmitter: it sends one command byte (LED set 0xED, enable 0xF4, reset 0xFF, …) from the Z80 I/O side to the keyboard and reports whether the device acknowledged it. It is the companion of the PS/2 receiver. It sits in the glue logic on CPUCLK and shares the open-drain PS/2 clock and data lines with the receiver. While `busy` is high, the top level masks receiver interrupts.

## Interface
Parameters:
- INHIBIT_TICKS, 12: clock-low inhibit length, in `tim_tick` periods (120 µs at a 10 µs tick).
- START_TO_TICKS, 1500: maximum wait for the device's first clock falling edge (15 ms).
- XFER_TO_TICKS, 200: maximum time from the first falling edge to the ack (2 ms).

Ports:
- clk  in  1  CPUCLK; the single clock. All logic is on its rising edge.
- res  in  1  asynchronous, active-high reset.
- tim_tick  in  1  one-`clk` enable pulse with a 10 µs period.
- tx_data  in  8  byte to send; captured on `tx_start`.
- tx_start  in  1  one-cycle request. Ignored while `busy` is high.
- ps2_clk_in  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin (asynchronous).
- ps2_clk_oe  out  1  1 drives the clock line low; 0 releases it.
- ps2_data_oe  out  1  1 drives the data line low; 0 releases it.
- busy  out  1  high from the accepted `tx_start` until `done`.
- done  out  1  one-cycle pulse when the transfer ends, by either success or failure.
- ack_ok  out  1  device acked; valid from `done` until the next accepted start.
- err  out  1  timeout or missing ack; valid from `done` until the next accepted start.

## Operation
Line conditioning:
- Both pins pass through a 2-flop synchronizer.
- A falling edge (`fe`) is the synced clock going 1→0.

Data framing:
- The frame shifts out LSB first.
- Parity is odd: the parity bit is ~^tx_data.
- On an accepted start, `tx_data` and the parity bit are loaded, and `ack_ok` and `err` are cleared.

State machine:
- IDLE: both OE are 0. `tx_start` moves to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1. Count `tim_tick`. After INHIBIT_TICKS ticks, set `ps2_data_oe`=1, then go to REQ.
- REQ: `ps2_clk_oe`=0 and `ps2_data_oe`=1; this is the start bit.
  - Count ticks.
  - On `fe`, set bit count to 0, clear the timer, and go to SHIFT.
  - If START_TO_TICKS ticks pass first, go to FAIL.
- SHIFT: on each `fe`, drive `ps2_data_oe` = ~bit, where bit is the current data, parity, or stop bit (stop = 1, so the line is released).
  - Falling edges 1–8 carry d0–d7, edge 9 carries parity, and edge 10 carries stop.
  - After edge 10, go to ACK.
- ACK: on the next `fe`, sample the synced data.
  - 0 sets `ack_ok`, then go to WAITREL.
  - 1 goes to FAIL.
- WAITREL: wait until both synced lines are 1, then go to FINISH.
- FINISH: pulse `done` and return to IDLE.
- FAIL: release both OE, set `err`, pulse `done`, and return to IDLE.

Timeouts and reset:
- The transfer timer runs in SHIFT, ACK and WAITREL. Reaching XFER_TO_TICKS goes to FAIL.
- Reset at any point releases both lines within the same cycle, because the OE registers are reset asynchronously.

## Timing
Reset values:
- `ps2_clk_oe`, `ps2_data_oe`, `busy`, `done`, `ack_ok` and `err` are all 0.
- The state is IDLE.

Latencies:
- `busy` goes high 1 `clk` after `tx_start`.
- `ps2_clk_oe` goes high in the same edge that sets `busy`.
- Data OE changes within 3 `clk` of the pin falling edge (2 sync + 1 register). The device half-period of at least 30 µs absorbs this.
- Inhibit lasts exactly INHIBIT_TICKS ticks. The error is −1 tick period, so with default INHIBIT_TICKS=12 the minimum is 110 µs, which still satisfies the 100 µs minimum.

Boundary conditions:
- `done` and `busy` falling happen in the same cycle.
- `tx_start` coinciding with `done` is ignored.
- `fe` and a timeout in the same cycle: the timeout wins.
- Extra `fe` in WAITREL are ignored.
- Timer widths are sized by $clog2 of the largest parameter.
- The bit counter is 4 bits and never wraps, because it exits at 10.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum `ps2_tx_state_t`;
  - default tick constants;
  - the `ps2_odd_parity` function, which the receiver also uses.
- One sub-module, `ps2_line_sync`, does the 2-flop sync plus fall-edge detect. The receiver reuses it for clock and data.

## Test plan
- Send 0xED (parity 1) with a device model clocking at 80 µs and acking:
  - clock low for ≥110 µs;
  - data bits sample as 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `done` with `ack_ok`=1 and `err`=0.
- Send 0xF4 (parity 0): the model checks parity = 0 and acks, giving `ack_ok`=1.
- Device never clocks: `err`=1 and `done` arrive at START_TO_TICKS+INHIBIT_TICKS ticks (about 15.12 ms), with both OE at 0 afterwards.
- Device stops after 5 edges: `err`=1 at XFER_TO_TICKS ticks after the first `fe`.
- Model leaves data high in the ack slot: `err`=1 and `ack_ok`=0.
- Assert `res` mid-SHIFT of 0xFF:
  - both OE are 0 immediately and `busy`=0;
  - a fresh `tx_start` of 0xFF after `res` deasserts then completes with `ack_ok`=1.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 types, default tick constants and parity helper    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_SHIFT   = 3'd3,
        S_ACK     = 3'd4,
        S_WAITREL = 3'd5,
        S_FINISH  = 3'd6,
        S_FAIL    = 3'd7
    } ps2_tx_state_t;

    localparam int c_default_inhibit_ticks  = 12;
    localparam int c_default_start_to_ticks = 1500;
    localparam int c_default_xfer_to_ticks  = 200;

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_line_sync : 2-flop synchronizer with falling-edge detect             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ps2_line_sync
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_transmitter : host-to-device PS/2 command byte sender with ack check |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_TICKS  = c_default_inhibit_ticks,
    parameter int START_TO_TICKS = c_default_start_to_ticks,
    parameter int XFER_TO_TICKS  = c_default_xfer_to_ticks
)(
    input  logic       clk,
    input  logic       res,
    input  logic       tim_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam int c_max_ab   = (INHIBIT_TICKS > START_TO_TICKS) ? INHIBIT_TICKS : START_TO_TICKS;
    localparam int c_max_tick = (c_max_ab > XFER_TO_TICKS) ? c_max_ab : XFER_TO_TICKS;
    localparam int c_tmr_w    = $clog2(c_max_tick);

    localparam logic [c_tmr_w-1:0] c_inhibit_last = c_tmr_w'(INHIBIT_TICKS - 1);
    localparam logic [c_tmr_w-1:0] c_start_last   = c_tmr_w'(START_TO_TICKS - 1);
    localparam logic [c_tmr_w-1:0] c_xfer_last    = c_tmr_w'(XFER_TO_TICKS - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one      = c_tmr_w'(1);

    ps2_tx_state_t       r_state,   w_state_nx;
    logic [c_tmr_w-1:0]  r_timer,   w_timer_nx;
    logic [3:0]          r_bit_cnt, w_bit_cnt_nx;
    logic [9:0]          r_shift,   w_shift_nx;
    logic                r_clk_oe,  w_clk_oe_nx;
    logic                r_data_oe, w_data_oe_nx;
    logic                r_busy,    w_busy_nx;
    logic                r_done,    w_done_nx;
    logic                r_ack_ok,  w_ack_ok_nx;
    logic                r_err,     w_err_nx;

    logic w_clk_lvl, w_clk_fall;
    logic w_data_lvl, w_data_fall;
    logic w_xfer_to;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .res     (res),
        .i_pin   (ps2_clk_in),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .res     (res),
        .i_pin   (ps2_data_in),
        .o_level (w_data_lvl),
        .o_fall  (w_data_fall)
    );

    assign w_xfer_to = tim_tick && (r_timer == c_xfer_last);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 10'd0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_ok  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_timer   <= w_timer_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_shift   <= w_shift_nx;
            r_clk_oe  <= w_clk_oe_nx;
            r_data_oe <= w_data_oe_nx;
            r_busy    <= w_busy_nx;
            r_done    <= w_done_nx;
            r_ack_ok  <= w_ack_ok_nx;
            r_err     <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_timer_nx   = r_timer;
        w_bit_cnt_nx = r_bit_cnt;
        w_shift_nx   = r_shift;
        w_clk_oe_nx  = r_clk_oe;
        w_data_oe_nx = r_data_oe;
        w_busy_nx    = r_busy;
        w_done_nx    = 1'b0;
        w_ack_ok_nx  = r_ack_ok;
        w_err_nx     = r_err;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nx  = 1'b0;
                w_data_oe_nx = 1'b0;
                // A start landing on the done pulse belongs to the old transfer.
                if (tx_start && !r_done) begin
                    w_state_nx  = S_INHIBIT;
                    w_clk_oe_nx = 1'b1;
                    w_busy_nx   = 1'b1;
                    w_ack_ok_nx = 1'b0;
                    w_err_nx    = 1'b0;
                    w_timer_nx  = '0;
                    w_shift_nx  = {1'b1, ps2_odd_parity(tx_data), tx_data};
                end
            end
            S_INHIBIT: begin
                // Data is pulled low one cycle before the clock is released.
                if (r_data_oe) begin
                    w_clk_oe_nx = 1'b0;
                    w_timer_nx  = '0;
                    w_state_nx  = S_REQ;
                end else if (tim_tick) begin
                    if (r_timer == c_inhibit_last) begin
                        w_data_oe_nx = 1'b1;
                    end else begin
                        w_timer_nx = r_timer + c_tmr_one;
                    end
                end
            end
            S_REQ: begin
                if (tim_tick && (r_timer == c_start_last)) begin
                    w_state_nx = S_FAIL;
                end else if (w_clk_fall) begin
                    w_bit_cnt_nx = 4'd0;
                    w_timer_nx   = '0;
                    w_state_nx   = S_SHIFT;
                end else if (tim_tick) begin
                    w_timer_nx = r_timer + c_tmr_one;
                end
            end
            S_SHIFT: begin
                if (w_xfer_to) begin
                    w_state_nx = S_FAIL;
                end else begin
                    if (tim_tick) w_timer_nx = r_timer + c_tmr_one;
                    if (w_clk_fall) begin
                        w_data_oe_nx = ~r_shift[0];
                        w_shift_nx   = {1'b0, r_shift[9:1]};
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd9) w_state_nx = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_xfer_to) begin
                    w_state_nx = S_FAIL;
                end else begin
                    if (tim_tick) w_timer_nx = r_timer + c_tmr_one;
                    if (w_clk_fall) begin
                        if (!w_data_lvl) begin
                            w_ack_ok_nx = 1'b1;
                            w_state_nx  = S_WAITREL;
                        end else begin
                            w_state_nx = S_FAIL;
                        end
                    end
                end
            end
            S_WAITREL: begin
                if (w_xfer_to) begin
                    w_state_nx = S_FAIL;
                end else begin
                    if (tim_tick) w_timer_nx = r_timer + c_tmr_one;
                    if (w_clk_lvl && w_data_lvl) w_state_nx = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            S_FAIL: begin
                w_clk_oe_nx  = 1'b0;
                w_data_oe_nx = 1'b0;
                w_err_nx     = 1'b1;
                w_done_nx    = 1'b1;
                w_busy_nx    = 1'b0;
                w_state_nx   = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign busy        = r_busy;
    assign done        = r_done;
    assign ack_ok      = r_ack_ok;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_transmitter : scoreboard bench with a behavioural PS/2 device     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ps2_transmitter;

    localparam int c_inhibit = 12;
    localparam int c_start_to = 1500;
    localparam int c_xfer_to = 200;

    logic       clk = 1'b0;
    logic       res;
    logic       tim_tick;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_line, ps2_data_line;

    int         checks = 0;
    int         errors = 0;
    int         tick_total = 0;
    int         done_cnt = 0;
    int         done_tick = 0;
    int         pend_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;

    assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_transmitter dut (
        .clk         (clk),
        .res         (res),
        .tim_tick    (tim_tick),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .err         (err)
    );

    always #5 clk = ~clk;

    // One clk period stands for 1 us, so a tick every 10 clocks is 10 us.
    initial begin
        tim_tick = 1'b0;
        forever begin
            repeat (9) @(negedge clk);
            tim_tick = 1'b1;
            @(negedge clk);
            tim_tick = 1'b0;
        end
    end

    always @(posedge clk) if (tim_tick) tick_total <= tick_total + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every done pulse consumes one expected {ack_ok, err}.
    always @(negedge clk) begin
        if (!res && done) begin
            done_tick = tick_total;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_ok", ack_ok, mon_e[1]);
                check("err", err, mon_e[0]);
                check("busy_at_done", busy, 0);
            end
            done_cnt++;
        end
    end

    task automatic start_tx(input logic [7:0] d, input bit exp_ack);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        pend_cnt = done_cnt;
        exp_q.push_back({exp_ack, ~exp_ack});
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_rise", busy, 1);
        check("clk_oe_rise", ps2_clk_oe, 1);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == pend_cnt && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == pend_cnt) check("done_timeout", 0, 1);
    endtask

    // Device side: clocks n_edges falling edges at 80 us period, samples on the
    // rising edge, and optionally pulls data low for the ack clock.
    task automatic device_xfer(input logic [7:0] d, input int n_edges, input bit do_ack,
                               output int first_fe_tick);
        logic [10:0] exp_frame;
        logic        par;
        int          n;
        first_fe_tick = 0;
        par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        exp_frame = {1'b1, par, d, 1'b0};
        n = 1;
        while (ps2_clk_oe === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_range("inhibit_len", n, 110, 130);
        n = 0;
        while (!(ps2_data_oe === 1'b1 && ps2_clk_oe === 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("request_seen", (n < 100), 1);
        wait_clks(30);
        for (int k = 0; k < 11 && k < n_edges; k++) begin
            dev_clk_low = 1'b1;
            if (k == 0) first_fe_tick = tick_total;
            wait_clks(40);
            dev_clk_low = 1'b0;
            wait_clks(20);
            check($sformatf("frame_bit%0d", k), ps2_data_line, exp_frame[k]);
            wait_clks(20);
        end
        if (n_edges > 11) begin
            if (do_ack) dev_data_low = 1'b1;
            wait_clks(20);
            dev_clk_low = 1'b1;
            wait_clks(40);
            dev_clk_low = 1'b0;
            wait_clks(20);
            dev_data_low = 1'b0;
        end
    endtask

    initial begin
        int         fe_tick;
        int         t0;
        logic [7:0] rd;
        bit         ra;
        int         n;

        res          = 1'b1;
        tx_data      = 8'h00;
        tx_start     = 1'b0;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        wait_clks(5);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_ok", ack_ok, 0);
        check("rst_err", err, 0);
        res = 1'b0;
        wait_clks(5);

        // 0xED with ack; a second start during busy must not disturb the frame.
        start_tx(8'hED, 1'b1);
        fork
            device_xfer(8'hED, 12, 1'b1, fe_tick);
            begin
                wait_clks(60);
                tx_data  = 8'h00;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                wait_done(5000);
            end
        join
        wait_clks(20);

        start_tx(8'hF4, 1'b1);
        fork
            device_xfer(8'hF4, 12, 1'b1, fe_tick);
            wait_done(5000);
        join
        wait_clks(20);

        // Device never clocks.
        start_tx(8'h12, 1'b0);
        t0 = tick_total;
        wait_done(20000);
        check("start_timeout_ticks", done_tick - t0, c_inhibit + c_start_to);
        wait_clks(1);
        check("fail_clk_oe", ps2_clk_oe, 0);
        check("fail_data_oe", ps2_data_oe, 0);
        wait_clks(20);

        // Device stops after 5 edges.
        start_tx(8'h3C, 1'b0);
        fork
            device_xfer(8'h3C, 5, 1'b1, fe_tick);
            wait_done(8000);
        join
        check_range("xfer_timeout_ticks", done_tick - fe_tick, c_xfer_to - 1, c_xfer_to + 1);
        wait_clks(20);

        // Device leaves data high in the ack slot.
        start_tx(8'h5A, 1'b0);
        fork
            device_xfer(8'h5A, 12, 1'b0, fe_tick);
            wait_done(5000);
        join
        wait_clks(20);

        for (int i = 0; i < 4; i++) begin
            rd = 8'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            start_tx(rd, ra);
            fork
                device_xfer(rd, 12, ra, fe_tick);
                wait_done(5000);
            join
            wait_clks(20);
        end

        // A start on the done cycle is ignored.
        start_tx(8'hA5, 1'b1);
        fork
            device_xfer(8'hA5, 12, 1'b1, fe_tick);
            begin
                n = 0;
                while (done !== 1'b1 && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                check("coincide_done_seen", (n < 5000), 1);
                tx_data  = 8'h77;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                check("coincide_busy", busy, 0);
                wait_clks(3);
                check("coincide_busy_later", busy, 0);
            end
        join
        wait_clks(20);

        // Reset mid-SHIFT of 0xFF, then a fresh 0xFF.
        start_tx(8'hFF, 1'b1);
        device_xfer(8'hFF, 5, 1'b1, fe_tick);
        wait_clks(7);
        res = 1'b1;
        #1;
        check("res_clk_oe", ps2_clk_oe, 0);
        check("res_data_oe", ps2_data_oe, 0);
        check("res_busy", busy, 0);
        exp_q.delete();
        wait_clks(3);
        res = 1'b0;
        wait_clks(5);
        start_tx(8'hFF, 1'b1);
        fork
            device_xfer(8'hFF, 12, 1'b1, fe_tick);
            wait_done(5000);
        join
        wait_clks(10);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
